// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : mem_arb_pkg                                                      |
// | Purpose  : Shared constants for the two-requester memory arbiter: FSM state |
// |            encodings, memory direction codes, default bus widths and the    |
// |            timeout counter width helper.                                    |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package mem_arb_pkg;

  localparam int DEFAULT_ADDR_W = 10;
  localparam int DEFAULT_DATA_W = 32;

  // Arbiter FSM states, 2-bit encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Memory transfer direction
  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  // Timeout counter width: at least 8 bits, wider when the limit needs it
  function automatic int cnt_width(input int limit);
    int w;
    w = $clog2(limit + 1);
    return (w < 8) ? 8 : w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : mem_arbiter_if                                                  |
// | Purpose   : Bundles both requester handshakes and the main-memory port.     |
// |             slave  = arbiter view, master = requesters + memory view.       |
// | Revision  : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W
) ();

  // Requester side
  logic              req0;
  logic              req1;
  logic              rw0;
  logic              rw1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              done0;
  logic              done1;
  logic              err0;
  logic              err1;
  logic [DATA_W-1:0] rdata;

  // Main-memory side
  logic              mem_valid;
  logic              mem_read_write;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_write_data;
  logic [DATA_W-1:0] mem_read_data;
  logic              mem_done;

  modport slave (
    input  req0, req1, rw0, rw1, addr0, addr1, wdata0, wdata1,
    input  mem_read_data, mem_done,
    output done0, done1, err0, err1, rdata,
    output mem_valid, mem_read_write, mem_address, mem_write_data
  );

  modport master (
    output req0, req1, rw0, rw1, addr0, addr1, wdata0, wdata1,
    output mem_read_data, mem_done,
    input  done0, done1, err0, err1, rdata,
    input  mem_valid, mem_read_write, mem_address, mem_write_data
  );

endinterface
`default_nettype wire

// File: rtl/arb_rr2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : arb_rr2                                                          |
// | Purpose  : Combinational 2-way round-robin picker. On a tie the requester   |
// |            that was not granted last wins. gnt_o = 0 selects requester 0.   |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module arb_rr2 (
  input  wire  req0_i,
  input  wire  req1_i,
  input  wire  last_grant_i,
  output logic gnt_valid_o,
  output logic gnt_o
);

  // Pick a winner from the current requests and the last grant
  always_comb begin
    gnt_valid_o = req0_i | req1_i;
    gnt_o       = 1'b0;
    if (req0_i && req1_i) begin
      gnt_o = ~last_grant_i;
    end else if (req1_i) begin
      gnt_o = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_arbiter                                                      |
// | Purpose  : Round-robin arbiter sharing one main-memory port between an      |
// |            instruction cache (req 0) and a data cache (req 1). Latches one  |
// |            whole transaction, holds the memory bus until mem_done, then     |
// |            returns rdata with a one-cycle done pulse.                       |
// | Options  : `define ARB_TIMEOUT_EN to abort BUSY after TIMEOUT_CYCLES cycles |
// |            with an err pulse; otherwise err0/err1 are tied low.             |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W         = DEFAULT_ADDR_W,
  parameter int DATA_W         = DEFAULT_DATA_W,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  wire          clk,
  input  wire          reset,
  mem_arbiter_if.slave bus
);

  logic [1:0]        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              gnt_q, gnt_d;
  logic              mem_valid_q, mem_valid_d;
  logic              mem_rw_q, mem_rw_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              done0_q, done0_d;
  logic              done1_q, done1_d;

  logic              pick_valid;
  logic              pick_gnt;
  logic              timeout_hit;

  arb_rr2 u_rr (
    .req0_i       (bus.req0),
    .req1_i       (bus.req1),
    .last_grant_i (last_grant_q),
    .gnt_valid_o  (pick_valid),
    .gnt_o        (pick_gnt)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int               CNT_W    = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err0_q, err0_d;
  logic             err1_q, err1_d;

  // The last permitted BUSY cycle is the one where the counter holds LIMIT-1
  assign timeout_hit = (state_q == ST_BUSY) && (cnt_q == CNT_LAST);

  // Counter restarts in IDLE, counts BUSY cycles; err flags the granted side on abort
  always_comb begin
    cnt_d  = cnt_q;
    err0_d = 1'b0;
    err1_d = 1'b0;
    case (state_q)
      ST_IDLE: cnt_d = '0;
      ST_BUSY: begin
        if (!bus.mem_done) begin
          if (timeout_hit) begin
            err0_d = ~gnt_q;
            err1_d = gnt_q;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: cnt_d = cnt_q;
    endcase
  end

  // Timeout counter and error flag registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      err0_q <= 1'b0;
      err1_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      err0_q <= err0_d;
      err1_q <= err1_d;
    end
  end

  assign bus.err0 = err0_q;
  assign bus.err1 = err1_q;
`else
  assign timeout_hit = 1'b0;
  assign bus.err0    = 1'b0;
  assign bus.err1    = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; mem_done only matters while BUSY
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (pick_valid) state_d = ST_BUSY;
      ST_BUSY: if (bus.mem_done || timeout_hit) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output/datapath next values: latch on grant, hold in BUSY, pulse done in RESP
  always_comb begin
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    mem_valid_d  = mem_valid_q;
    mem_rw_d     = mem_rw_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    rdata_d      = rdata_q;
    done0_d      = 1'b0;
    done1_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          gnt_d       = pick_gnt;
          mem_valid_d = 1'b1;
          mem_rw_d    = pick_gnt ? bus.rw1    : bus.rw0;
          mem_addr_d  = pick_gnt ? bus.addr1  : bus.addr0;
          mem_wdata_d = pick_gnt ? bus.wdata1 : bus.wdata0;
        end
      end
      ST_BUSY: begin
        if (bus.mem_done || timeout_hit) begin
          mem_valid_d  = 1'b0;
          last_grant_d = gnt_q;
          done0_d      = ~gnt_q;
          done1_d      = gnt_q;
          // A real completion wins over a coincident timeout
          if (bus.mem_done) begin
            if (mem_rw_q == MEM_READ) rdata_d = bus.mem_read_data;
          end else begin
            rdata_d = '0;
          end
        end
      end
      default: begin
        // RESP: done pulses fall back to zero through the defaults
      end
    endcase
  end

  // Datapath and handshake registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      mem_valid_q  <= 1'b0;
      mem_rw_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rdata_q      <= '0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      mem_valid_q  <= mem_valid_d;
      mem_rw_q     <= mem_rw_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      rdata_q      <= rdata_d;
      done0_q      <= done0_d;
      done1_q      <= done1_d;
    end
  end

  assign bus.mem_valid      = mem_valid_q;
  assign bus.mem_read_write = mem_rw_q;
  assign bus.mem_address    = mem_addr_q;
  assign bus.mem_write_data = mem_wdata_q;
  assign bus.rdata          = rdata_q;
  assign bus.done0          = done0_q;
  assign bus.done1          = done1_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mem_arbiter                                                   |
// | Purpose  : Self-checking bench for mem_arbiter: directed scenarios plus a   |
// |            randomized run against a transaction-level arbitration model.    |
// |            Timeout scenarios build only with `define ARB_TIMEOUT_EN.        |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_mem_arbiter;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
`ifdef ARB_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 64;
`endif

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_arbiter #(
    .ADDR_W         (ADDR_W),
    .DATA_W         (DATA_W),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge
  task automatic apply_reset();
    reset = 1'b1;
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.rw0 = 1'b0; bus.rw1 = 1'b0;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
    bus.mem_read_data = '0; bus.mem_done = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Memory-side driver: wait for the grant, answer after k BUSY edges, capture the response
  task automatic run_txn(input int k, input logic [DATA_W-1:0] md,
                         output bit seen, output logic [ADDR_W-1:0] a, output logic rw,
                         output logic [DATA_W-1:0] wd, output logic d0, output logic d1,
                         output logic e0, output logic e1, output logic [DATA_W-1:0] rd);
    seen = 1'b0; a = '0; rw = 1'b0; wd = '0; d0 = 1'b0; d1 = 1'b0; e0 = 1'b0; e1 = 1'b0; rd = '0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      if (bus.mem_valid === 1'b1) seen = 1'b1;
    end
    if (!seen) return;
    a = bus.mem_address; rw = bus.mem_read_write; wd = bus.mem_write_data;
    repeat (k - 1) @(negedge clk);
    bus.mem_done = 1'b1;
    bus.mem_read_data = md;
    @(negedge clk);
    d0 = bus.done0; d1 = bus.done1; e0 = bus.err0; e1 = bus.err1; rd = bus.rdata;
    bus.mem_done = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    reset = 1'b1;
    #1;
    n_checks++;
    if ({bus.done0, bus.done1, bus.err0, bus.err1, bus.mem_valid, bus.mem_read_write} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 000000",
               {bus.done0, bus.done1, bus.err0, bus.err1, bus.mem_valid, bus.mem_read_write});
    end
    n_checks++;
    if ({bus.mem_address, bus.mem_write_data, bus.rdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_buses: addr %h wdata %h rdata %h expected all zero",
               bus.mem_address, bus.mem_write_data, bus.rdata);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_read();
    bit seen; logic [ADDR_W-1:0] a; logic rw, d0, d1, e0, e1; logic [DATA_W-1:0] wd, rd;
    apply_reset();
    bus.req0 = 1'b1; bus.rw0 = 1'b0; bus.addr0 = 10'h004; bus.wdata0 = $urandom;
    run_txn(3, 32'h1234_5678, seen, a, rw, wd, d0, d1, e0, e1, rd);
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL single_valid: mem_valid got 0 expected 1"); end
    n_checks++;
    if (a !== 10'h004 || rw !== 1'b0) begin
      n_fail++; $display("FAIL single_addr: got addr %h rw %b expected 004 0", a, rw);
    end
    n_checks++;
    if ({d0, d1, e0, e1} !== 4'b1000 || rd !== 32'h1234_5678) begin
      n_fail++; $display("FAIL single_done: got d0d1e0e1 %b rdata %h expected 1000 12345678", {d0, d1, e0, e1}, rd);
    end
    bus.req0 = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus.done0, bus.done1, bus.mem_valid} !== 3'b000) begin
      n_fail++; $display("FAIL single_pulse_end: got %b expected 000", {bus.done0, bus.done1, bus.mem_valid});
    end
  endtask

  task automatic test_simultaneous();
    bit seen; logic [ADDR_W-1:0] a; logic rw, d0, d1, e0, e1; logic [DATA_W-1:0] wd, rd, md, prev_rd;
    int last, exp_w;
    apply_reset();
    last = 1; prev_rd = '0;
    bus.req0 = 1'b1; bus.rw0 = 1'b1; bus.addr0 = 10'h010; bus.wdata0 = 32'hAAAA_0000;
    bus.req1 = 1'b1; bus.rw1 = 1'b0; bus.addr1 = 10'h020; bus.wdata1 = 32'h5555_5555;
    // Both held continuously: grants must go 0,1,0,1,0,1
    for (int t = 0; t < 6; t++) begin
      exp_w = 1 - last;
      md = $urandom;
      run_txn($urandom_range(1, 4), md, seen, a, rw, wd, d0, d1, e0, e1, rd);
      n_checks++;
      if (!seen || a !== (exp_w ? 10'h020 : 10'h010) || rw !== (exp_w == 0)) begin
        n_fail++; $display("FAIL alt_grant[%0d]: got valid %b addr %h rw %b expected requester %0d", t, seen, a, rw, exp_w);
      end
      if (exp_w == 0) begin
        n_checks++;
        if (wd !== 32'hAAAA_0000) begin n_fail++; $display("FAIL alt_wdata[%0d]: got %h expected aaaa0000", t, wd); end
      end else begin
        prev_rd = md;
      end
      n_checks++;
      if (d0 !== (exp_w == 0) || d1 !== (exp_w == 1) || rd !== prev_rd) begin
        n_fail++; $display("FAIL alt_done[%0d]: got d0 %b d1 %b rdata %h expected requester %0d rdata %h", t, d0, d1, rd, exp_w, prev_rd);
      end
      last = exp_w;
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_midbusy_change();
    bit seen;
    apply_reset();
    bus.req0 = 1'b1; bus.rw0 = 1'b0; bus.addr0 = 10'h004;
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      @(negedge clk);
      if (bus.mem_valid === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL midbusy_valid: mem_valid got 0 expected 1"); end
    bus.addr0 = 10'h3FF; bus.rw0 = 1'b1; bus.wdata0 = $urandom;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.mem_address !== 10'h004 || bus.mem_read_write !== 1'b0 || bus.mem_valid !== 1'b1) begin
        n_fail++; $display("FAIL midbusy_hold[%0d]: got addr %h rw %b valid %b expected 004 0 1",
                           i, bus.mem_address, bus.mem_read_write, bus.mem_valid);
      end
    end
    bus.mem_done = 1'b1; bus.mem_read_data = 32'hCAFE_F00D;
    @(negedge clk);
    bus.mem_done = 1'b0;
    n_checks++;
    if (bus.done0 !== 1'b1 || bus.mem_address !== 10'h004 || bus.rdata !== 32'hCAFE_F00D) begin
      n_fail++; $display("FAIL midbusy_done: got done0 %b addr %h rdata %h expected 1 004 cafef00d",
                         bus.done0, bus.mem_address, bus.rdata);
    end
    bus.req0 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    bit seen; logic [ADDR_W-1:0] a; logic rw, d0, d1, e0, e1; logic [DATA_W-1:0] wd, rd;
    apply_reset();
    bus.req1 = 1'b1; bus.rw1 = 1'b1; bus.addr1 = 10'h155; bus.wdata1 = 32'hDEAD_BEEF;
    @(negedge clk);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({bus.mem_valid, bus.mem_read_write, bus.done0, bus.done1} !== 4'b0000 ||
        bus.mem_address !== '0 || bus.mem_write_data !== '0) begin
      n_fail++; $display("FAIL async_reset: got valid %b rw %b addr %h wdata %h expected zeros",
                         bus.mem_valid, bus.mem_read_write, bus.mem_address, bus.mem_write_data);
    end
    @(negedge clk);
    reset = 1'b0;
    bus.req0 = 1'b1; bus.rw0 = 1'b0; bus.addr0 = 10'h0AB;
    run_txn(2, 32'h0BAD_CAFE, seen, a, rw, wd, d0, d1, e0, e1, rd);
    n_checks++;
    if (!seen || a !== 10'h0AB || d0 !== 1'b1 || d1 !== 1'b0) begin
      n_fail++; $display("FAIL async_tie: got valid %b addr %h d0 %b d1 %b expected 1 0ab 1 0", seen, a, d0, d1);
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_stray_done();
    apply_reset();
    bus.mem_done = 1'b1; bus.mem_read_data = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if ({bus.done0, bus.done1, bus.mem_valid} !== 3'b000 || bus.rdata !== '0) begin
        n_fail++; $display("FAIL stray_done[%0d]: got d0d1v %b rdata %h expected 000 0",
                           i, {bus.done0, bus.done1, bus.mem_valid}, bus.rdata);
      end
    end
    bus.mem_done = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    bit seen; logic [ADDR_W-1:0] a, a0, a1, exp_a; logic rw, rw0, rw1, exp_rw, d0, d1, e0, e1;
    logic [DATA_W-1:0] wd, rd, w0, w1, exp_wd, md, exp_rd;
    int last, exp_w, pat;
    apply_reset();
    last = 1; exp_rd = '0;
    for (int r = 0; r < 40; r++) begin
      pat = $urandom_range(0, 3);
      if (pat == 0) begin
        bus.mem_done = 1'($urandom_range(0, 1));
        @(negedge clk);
        bus.mem_done = 1'b0;
        n_checks++;
        if ({bus.done0, bus.done1, bus.mem_valid} !== 3'b000) begin
          n_fail++; $display("FAIL rnd_idle[%0d]: got d0d1v %b expected 000", r, {bus.done0, bus.done1, bus.mem_valid});
        end
      end else begin
        a0 = ADDR_W'($urandom); a1 = ADDR_W'($urandom);
        rw0 = 1'($urandom); rw1 = 1'($urandom); w0 = $urandom; w1 = $urandom; md = $urandom;
        bus.req0 = (pat != 2); bus.req1 = (pat != 1);
        bus.addr0 = a0; bus.addr1 = a1; bus.rw0 = rw0; bus.rw1 = rw1; bus.wdata0 = w0; bus.wdata1 = w1;
        exp_w  = (pat == 3) ? 1 - last : pat - 1;
        exp_a  = exp_w ? a1 : a0;
        exp_rw = exp_w ? rw1 : rw0;
        exp_wd = exp_w ? w1 : w0;
        if (!exp_rw) exp_rd = md;
        run_txn($urandom_range(1, 6), md, seen, a, rw, wd, d0, d1, e0, e1, rd);
        n_checks++;
        if (!seen || a !== exp_a || rw !== exp_rw || (exp_rw && wd !== exp_wd)) begin
          n_fail++; $display("FAIL rnd_bus[%0d]: got v %b addr %h rw %b wd %h expected addr %h rw %b wd %h",
                             r, seen, a, rw, wd, exp_a, exp_rw, exp_wd);
        end
        n_checks++;
        if (d0 !== (exp_w == 0) || d1 !== (exp_w == 1) || rd !== exp_rd || {e0, e1} !== 2'b00) begin
          n_fail++; $display("FAIL rnd_resp[%0d]: got d0 %b d1 %b err %b rdata %h expected requester %0d rdata %h",
                             r, d0, d1, {e0, e1}, rd, exp_w, exp_rd);
        end
        last = exp_w;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus.done0, bus.done1} !== 2'b00) begin
          n_fail++; $display("FAIL rnd_pulse[%0d]: got d0d1 %b expected 00", r, {bus.done0, bus.done1});
        end
      end
    end
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    bit seen; logic [ADDR_W-1:0] a; logic rw, d0, d1, e0, e1; logic [DATA_W-1:0] wd, rd;
    int cnt;
    apply_reset();
    // mem_done on the last allowed BUSY cycle is a normal completion
    bus.req1 = 1'b1; bus.rw1 = 1'b0; bus.addr1 = 10'h0C0;
    run_txn(TMO, 32'h7777_1111, seen, a, rw, wd, d0, d1, e0, e1, rd);
    n_checks++;
    if (!seen || d1 !== 1'b1 || e1 !== 1'b0 || rd !== 32'h7777_1111) begin
      n_fail++; $display("FAIL tmo_edge_done: got d1 %b err1 %b rdata %h expected 1 0 77771111", d1, e1, rd);
    end
    bus.req1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.req1 = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      @(negedge clk);
      if (bus.mem_valid === 1'b1) seen = 1'b1;
    end
    cnt = 0;
    while (bus.done1 !== 1'b1 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    n_checks++;
    if (!seen || cnt != TMO) begin
      n_fail++; $display("FAIL tmo_cycles: got %0d busy cycles expected %0d", cnt, TMO);
    end
    n_checks++;
    if (bus.err1 !== 1'b1 || bus.rdata !== '0 || bus.done0 !== 1'b0 || bus.err0 !== 1'b0) begin
      n_fail++; $display("FAIL tmo_abort: got err1 %b rdata %h done0 %b err0 %b expected 1 0 0 0",
                         bus.err1, bus.rdata, bus.done0, bus.err0);
    end
    bus.req1 = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus.done1, bus.err1, bus.mem_valid} !== 3'b000) begin
      n_fail++; $display("FAIL tmo_clear: got d1e1v %b expected 000", {bus.done1, bus.err1, bus.mem_valid});
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_read();
    test_simultaneous();
    test_midbusy_change();
    test_async_reset();
    test_stray_done();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
